// File: rtl/ym3438_pkg.sv
// Shared constants, register decode and channel-index helpers for the
// YM3438 LFO/channel-parameter control slice.
package ym3438_pkg;

  localparam int NUM_SLOTS   = 24;
  localparam int NUM_CH      = 6;
  localparam int NUM_PHASES  = 6;
  localparam int BUSY_CYCLES = 12;

  localparam logic [7:0] ADDR_TEST    = 8'h21;
  localparam logic [7:0] ADDR_LFO     = 8'h22;
  localparam logic [7:0] ADDR_FNUM_LO = 8'hA0;
  localparam logic [7:0] ADDR_FNUM_HI = 8'hA4;
  localparam logic [7:0] ADDR_PMS     = 8'hB4;

  localparam logic [2:0] PHASE_LAST = 3'(NUM_PHASES - 1);
  localparam logic [2:0] PHASE_C2   = 3'd3;
  localparam logic [4:0] SLOT_LAST  = 5'(NUM_SLOTS - 1);
  localparam logic [2:0] CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [3:0] BUSY_LOAD  = 4'(BUSY_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TEST,
    REG_LFO,
    REG_HI,
    REG_LO,
    REG_PMS
  } reg_kind_t;

  // Channel-group registers ignore the low two address bits except value 3.
  function automatic reg_kind_t decode_reg(input logic port, input logic [7:0] addr);
    reg_kind_t kind;
    kind = REG_NONE;
    if (addr == ADDR_TEST) begin
      kind = port ? REG_NONE : REG_TEST;
    end else if (addr == ADDR_LFO) begin
      kind = port ? REG_NONE : REG_LFO;
    end else if (addr[1:0] != 2'd3) begin
      case ({addr[7:2], 2'b00})
        ADDR_FNUM_HI: kind = REG_HI;
        ADDR_FNUM_LO: kind = REG_LO;
        ADDR_PMS:     kind = REG_PMS;
        default:      kind = REG_NONE;
      endcase
    end else begin
      kind = REG_NONE;
    end
    return kind;
  endfunction

  function automatic logic [2:0] ch_idx(input logic port, input logic [1:0] sel);
    return (port ? 3'd3 : 3'd0) + {1'b0, sel};
  endfunction

endpackage

// File: rtl/ym3438_lfo_ch_regs.sv
// Six-entry per-channel parameter store (pms, fnum, block) with one write
// port and one read port; a same-cycle write is forwarded to the read port.
module ym3438_lfo_ch_regs
  import ym3438_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we_pms,
  input  logic        i_we_fb,
  input  logic [2:0]  i_widx,
  input  logic [2:0]  i_wpms,
  input  logic [10:0] i_wfnum,
  input  logic [2:0]  i_wblock,
  input  logic [2:0]  i_ridx,
  output logic [2:0]  o_pms,
  output logic [10:0] o_fnum,
  output logic [2:0]  o_block
);

  logic [2:0]  r_pms   [NUM_CH];
  logic [10:0] r_fnum  [NUM_CH];
  logic [2:0]  r_block [NUM_CH];
  logic        w_hit_pms;
  logic        w_hit_fb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pms[i]   <= 3'd0;
        r_fnum[i]  <= 11'd0;
        r_block[i] <= 3'd0;
      end
    end else begin
      if (i_we_pms) begin
        r_pms[i_widx] <= i_wpms;
      end
      if (i_we_fb) begin
        r_fnum[i_widx]  <= i_wfnum;
        r_block[i_widx] <= i_wblock;
      end
    end
  end

  assign w_hit_pms = i_we_pms && (i_widx == i_ridx);
  assign w_hit_fb  = i_we_fb && (i_widx == i_ridx);
  assign o_pms     = w_hit_pms ? i_wpms : r_pms[i_ridx];
  assign o_fnum    = w_hit_fb ? i_wfnum : r_fnum[i_ridx];
  assign o_block   = w_hit_fb ? i_wblock : r_block[i_ridx];

endmodule

// File: rtl/ym3438_lfo_ctrl.sv
// YM3438 slot/phase timing plus the write path for the LFO, test and
// per-channel pitch registers; channel parameters are presented per slot.
module ym3438_lfo_ctrl
  import ym3438_pkg::*;
(
  input  logic        MCLK,
  input  logic        IC,
  input  logic        wr_en,
  input  logic        wr_port,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        c1,
  output logic        c2,
  output logic        fsm_sel23,
  output logic [3:0]  lfo,
  output logic [7:0]  reg_21,
  output logic [2:0]  pms,
  output logic [10:0] fnum,
  output logic [2:0]  block
);

  logic [2:0]  r_phase, w_phase_nxt;
  logic [4:0]  r_slot, w_slot_nxt;
  logic [2:0]  r_ch, w_ch_nxt;
  logic        w_phase0;
  logic        r_c1, r_c2, r_sel23;

  logic        r_busy;
  logic [3:0]  r_busy_cnt;
  logic        w_accept, w_commit;
  logic        r_pend_vld, r_pend_port;
  reg_kind_t   r_pend_kind;
  logic [2:0]  r_pend_idx;
  logic [7:0]  r_pend_data;

  logic [5:0]  r_hi0, r_hi1, w_hi_sel;
  logic [3:0]  r_lfo;
  logic [7:0]  r_reg21;
  logic [2:0]  r_pms, w_rd_pms;
  logic [10:0] r_fnum, w_rd_fnum;
  logic [2:0]  r_block, w_rd_block;

  // Everything that happens "on entry to phase 0" keys off the last phase.
  assign w_phase0    = (r_phase == PHASE_LAST);
  assign w_phase_nxt = w_phase0 ? 3'd0 : r_phase + 3'd1;
  assign w_slot_nxt  = !w_phase0 ? r_slot : ((r_slot == SLOT_LAST) ? 5'd0 : r_slot + 5'd1);
  assign w_ch_nxt    = !w_phase0 ? r_ch : ((r_ch == CH_LAST) ? 3'd0 : r_ch + 3'd1);

  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_phase <= 3'd0;
      r_slot  <= 5'd0;
      r_ch    <= 3'd0;
      r_c1    <= 1'b0;
      r_c2    <= 1'b0;
      r_sel23 <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_slot  <= w_slot_nxt;
      r_ch    <= w_ch_nxt;
      r_c1    <= w_phase0;
      r_c2    <= (w_phase_nxt == PHASE_C2);
      r_sel23 <= (w_slot_nxt == SLOT_LAST);
    end
  end

  assign w_accept = wr_en && !r_busy;
  assign w_commit = r_pend_vld && w_phase0;

  // Busy outlasts the pending commit, so accept and commit never coincide.
  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_busy      <= 1'b0;
      r_busy_cnt  <= 4'd0;
      r_pend_vld  <= 1'b0;
      r_pend_port <= 1'b0;
      r_pend_kind <= REG_NONE;
      r_pend_idx  <= 3'd0;
      r_pend_data <= 8'd0;
    end else begin
      if (w_commit) begin
        r_pend_vld <= 1'b0;
      end
      if (w_accept) begin
        r_busy      <= 1'b1;
        r_busy_cnt  <= BUSY_LOAD;
        r_pend_vld  <= 1'b1;
        r_pend_port <= wr_port;
        r_pend_kind <= decode_reg(wr_port, wr_addr);
        r_pend_idx  <= ch_idx(wr_port, wr_addr[1:0]);
        r_pend_data <= wr_data;
      end else if (r_busy) begin
        if (r_busy_cnt == 4'd0) begin
          r_busy <= 1'b0;
        end else begin
          r_busy_cnt <= r_busy_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_hi0   <= 6'd0;
      r_hi1   <= 6'd0;
      r_lfo   <= 4'd0;
      r_reg21 <= 8'd0;
    end else if (w_commit) begin
      case (r_pend_kind)
        REG_TEST: r_reg21 <= r_pend_data;
        REG_LFO:  r_lfo   <= r_pend_data[3:0];
        REG_HI: begin
          if (r_pend_port) begin
            r_hi1 <= r_pend_data[5:0];
          end else begin
            r_hi0 <= r_pend_data[5:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign w_hi_sel = r_pend_port ? r_hi1 : r_hi0;

  ym3438_lfo_ch_regs u_ch_regs (
    .i_clk    (MCLK),
    .i_rst    (IC),
    .i_we_pms (w_commit && (r_pend_kind == REG_PMS)),
    .i_we_fb  (w_commit && (r_pend_kind == REG_LO)),
    .i_widx   (r_pend_idx),
    .i_wpms   (r_pend_data[2:0]),
    .i_wfnum  ({w_hi_sel[2:0], r_pend_data}),
    .i_wblock (w_hi_sel[5:3]),
    .i_ridx   (w_ch_nxt),
    .o_pms    (w_rd_pms),
    .o_fnum   (w_rd_fnum),
    .o_block  (w_rd_block)
  );

  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_pms   <= 3'd0;
      r_fnum  <= 11'd0;
      r_block <= 3'd0;
    end else if (w_phase0) begin
      r_pms   <= w_rd_pms;
      r_fnum  <= w_rd_fnum;
      r_block <= w_rd_block;
    end
  end

  assign busy      = r_busy;
  assign c1        = r_c1;
  assign c2        = r_c2;
  assign fsm_sel23 = r_sel23;
  assign lfo       = r_lfo;
  assign reg_21    = r_reg21;
  assign pms       = r_pms;
  assign fnum      = r_fnum;
  assign block     = r_block;

endmodule
